// File: rtl/hdmi_pattern_tx.sv
// hdmi_pattern_tx
// Stand-alone 640x480 test-pattern source for the Nexys3. All logic runs on
// the 100 MHz board clock; a pixel is produced every PIX_DIV (=10) cycles,
// which is also the TMDS word length, so each lane shifts out one bit per
// clock with no second clock domain.
//
// Ports:
//   CLK100      100 MHz system clock (rising edge)
//   btns        asynchronous active-high reset
//   btnd        raw pattern-advance pushbutton (synchronised and debounced here)
//   TX0_TMDS_P  TMDS serial data, [0]=blue [1]=green [2]=red [3]=clock lane
//   TX0_TMDS_N  complement of TX0_TMDS_P
//   Hsync       VGA horizontal sync, active-low
//   Vsync       VGA vertical sync, active-low
//   vgaRed      red[7:5]
//   vgaGreen    green[7:5]
//   vgaBlue     blue[7:6]
module hdmi_pattern_tx #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PIX_DIV         = 10
) (
  input  logic       CLK100,
  input  logic       btns,
  input  logic       btnd,
  output logic [3:0] TX0_TMDS_P,
  output logic [3:0] TX0_TMDS_N,
  output logic       Hsync,
  output logic       Vsync,
  output logic [2:0] vgaRed,
  output logic [2:0] vgaGreen,
  output logic [1:0] vgaBlue
);

  localparam int              DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      PHASE_LAST = 4'(PIX_DIV - 1);

  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;

  // The clock lane is a 50% duty square wave at the pixel rate, low half first.
  localparam logic [9:0] CLK_WORD = 10'b1111100000;

  typedef struct packed {
    logic [9:0]        word;
    logic signed [5:0] disp;
  } tmds_t;

  logic [3:0]        phase;
  logic              pix_en;
  logic [9:0]        hcnt;
  logic [9:0]        vcnt;
  logic [1:0]        pattern;
  logic              btn_meta;
  logic              btn_sync;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic [2:0]        bar;
  logic              next_de;
  logic              next_hs;
  logic              next_vs;
  logic [7:0]        next_r;
  logic [7:0]        next_g;
  logic [7:0]        next_b;
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic              pix_de;
  logic              pix_hs;
  logic              pix_vs;
  logic signed [5:0] disp_b;
  logic signed [5:0] disp_g;
  logic signed [5:0] disp_r;
  tmds_t             enc_b;
  tmds_t             enc_g;
  tmds_t             enc_r;
  logic [3:0][9:0]   shift_q;

  // DVI 1.0 8b/10b encoder. Outside active video the control token is sent and
  // the running disparity collapses to zero.
  function automatic tmds_t tmds_encode(input logic [7:0]        d,
                                        input logic [1:0]        ctrl,
                                        input logic              active,
                                        input logic signed [5:0] disp_in);
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              xnor_sel;
    logic [8:0]        qm;
    logic signed [5:0] diff;
    logic signed [5:0] two_qm8;
    logic signed [5:0] two_nqm8;
    tmds_t             res;
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    xnor_sel = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm    = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnor_sel ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xnor_sel;
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
    // diff is (ones - zeros) of the 8 data bits, i.e. 2*n1q - 8.
    diff     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    two_qm8  = $signed({4'b0000, qm[8], 1'b0});
    two_nqm8 = $signed({4'b0000, ~qm[8], 1'b0});
    if (!active) begin
      res.disp = 6'sd0;
      case (ctrl)
        2'b00:   res.word = 10'b1101010100;
        2'b01:   res.word = 10'b0010101011;
        2'b10:   res.word = 10'b0101010100;
        default: res.word = 10'b1010101011;
      endcase
    end else if ((disp_in == 6'sd0) || (diff == 6'sd0)) begin
      res.word = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      res.disp = qm[8] ? (disp_in + diff) : (disp_in - diff);
    end else if ((!disp_in[5] && (diff > 6'sd0)) || (disp_in[5] && (diff < 6'sd0))) begin
      res.word = {1'b1, qm[8], ~qm[7:0]};
      res.disp = disp_in + two_qm8 - diff;
    end else begin
      res.word = {1'b0, qm[8], qm[7:0]};
      res.disp = disp_in - two_nqm8 + diff;
    end
    return res;
  endfunction

  assign pix_en = (phase == PHASE_LAST);

  // Pixel-rate divider plus the raster counters. The counters step once per
  // pixel and describe the pixel being generated right now; the pixel stage
  // below captures them, so the pins trail the counters by one pixel.
  always_ff @(posedge CLK100 or posedge btns) begin
    if (btns) begin
      phase <= 4'd0;
      hcnt  <= 10'd0;
      vcnt  <= 10'd0;
    end else begin
      phase <= pix_en ? 4'd0 : phase + 4'd1;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= 10'd0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Button path: two flops to tame metastability, then a counter that only
  // lets a new level through once it has been held for DEBOUNCE_CYCLES
  // consecutive clocks. Only the rising transition of the clean level steps
  // the pattern, so holding the button gives a single advance.
  always_ff @(posedge CLK100 or posedge btns) begin
    if (btns) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      pattern  <= 2'd0;
    end else begin
      btn_meta <= btnd;
      btn_sync <= btn_meta;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= btn_sync;
        if (btn_sync) pattern <= pattern + 2'd1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Colour and sync for the pixel the counters point at. Bar index 0..7 maps
  // white, yellow, cyan, green, magenta, red, blue, black: red is off for
  // bars 2,3,6,7, green for 4..7, blue for odd bars.
  always_comb begin
    bar     = 3'(hcnt / 10'd80);
    next_de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
    next_hs = !((hcnt >= H_SYNC_LO) && (hcnt <= H_SYNC_HI));
    next_vs = !((vcnt >= V_SYNC_LO) && (vcnt <= V_SYNC_HI));
    next_r  = 8'h00;
    next_g  = 8'h00;
    next_b  = 8'h00;
    case (pattern)
      2'd0: begin
        next_r = {8{~bar[1]}};
        next_g = {8{~bar[2]}};
        next_b = {8{~bar[0]}};
      end
      2'd1: begin
        next_r = {8{hcnt[5] ^ vcnt[5]}};
        next_g = {8{hcnt[5] ^ vcnt[5]}};
        next_b = {8{hcnt[5] ^ vcnt[5]}};
      end
      2'd2: begin
        next_r = hcnt[9:2];
        next_g = vcnt[8:1];
      end
      default: begin
        next_r = 8'hFF;
        next_g = 8'hFF;
        next_b = 8'hFF;
      end
    endcase
    if (!next_de) begin
      next_r = 8'h00;
      next_g = 8'h00;
      next_b = 8'h00;
    end
  end

  // Pixel stage: one register set feeds both the VGA pins and the TMDS
  // encoders, so the two outputs always show the same picture.
  always_ff @(posedge CLK100 or posedge btns) begin
    if (btns) begin
      pix_r  <= 8'h00;
      pix_g  <= 8'h00;
      pix_b  <= 8'h00;
      pix_de <= 1'b0;
      pix_hs <= 1'b1;
      pix_vs <= 1'b1;
    end else if (pix_en) begin
      pix_r  <= next_r;
      pix_g  <= next_g;
      pix_b  <= next_b;
      pix_de <= next_de;
      pix_hs <= next_hs;
      pix_vs <= next_vs;
    end
  end

  assign enc_b = tmds_encode(pix_b, {pix_vs, pix_hs}, pix_de, disp_b);
  assign enc_g = tmds_encode(pix_g, 2'b00,            pix_de, disp_g);
  assign enc_r = tmds_encode(pix_r, 2'b00,            pix_de, disp_r);

  // Serialiser: on the pixel tick every lane loads its freshly encoded word
  // and the disparities commit; on the nine clocks in between the words
  // shift right so bit 0 goes out first.
  always_ff @(posedge CLK100 or posedge btns) begin
    if (btns) begin
      shift_q <= '0;
      disp_b  <= 6'sd0;
      disp_g  <= 6'sd0;
      disp_r  <= 6'sd0;
    end else if (pix_en) begin
      shift_q[0] <= enc_b.word;
      shift_q[1] <= enc_g.word;
      shift_q[2] <= enc_r.word;
      shift_q[3] <= CLK_WORD;
      disp_b     <= enc_b.disp;
      disp_g     <= enc_g.disp;
      disp_r     <= enc_r.disp;
    end else begin
      for (int i = 0; i < 4; i++) shift_q[i] <= {1'b0, shift_q[i][9:1]};
    end
  end

  assign TX0_TMDS_P = {shift_q[3][0], shift_q[2][0], shift_q[1][0], shift_q[0][0]};
  assign TX0_TMDS_N = ~TX0_TMDS_P;
  assign Hsync      = pix_hs;
  assign Vsync      = pix_vs;
  assign vgaRed     = pix_r[7:5];
  assign vgaGreen   = pix_g[7:5];
  assign vgaBlue    = pix_b[7:6];

endmodule

// File: tb/tb_hdmi_pattern_tx.sv
// tb_hdmi_pattern_tx
// Randomised bench for hdmi_pattern_tx. The button is driven with random
// glitches and holds; a reference model derived from the raster position,
// the pattern definitions and the DVI encoding rules predicts every output
// pin on every clock.
module tb_hdmi_pattern_tx;

  localparam int DB = 16;

  logic       CLK100 = 1'b0;
  logic       btns;
  logic       btnd;
  logic [3:0] TX0_TMDS_P;
  logic [3:0] TX0_TMDS_N;
  logic       Hsync;
  logic       Vsync;
  logic [2:0] vgaRed;
  logic [2:0] vgaGreen;
  logic [1:0] vgaBlue;

  hdmi_pattern_tx #(.DEBOUNCE_CYCLES(DB), .PIX_DIV(10)) dut (
    .CLK100     (CLK100),
    .btns       (btns),
    .btnd       (btnd),
    .TX0_TMDS_P (TX0_TMDS_P),
    .TX0_TMDS_N (TX0_TMDS_N),
    .Hsync      (Hsync),
    .Vsync      (Vsync),
    .vgaRed     (vgaRed),
    .vgaGreen   (vgaGreen),
    .vgaBlue    (vgaBlue)
  );

  always #5 CLK100 = ~CLK100;

  int checks = 0;
  int errors = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Model state: e counts rising edges since reset release.
  int         e;
  int         pix_count;
  int         m_pat;
  int         inc_edge;
  int         high_left;
  int         low_left;
  int         load_edge;
  bit         loaded;
  int         m_disp [3];
  logic [9:0] m_word [4];
  logic [7:0] m_r, m_g, m_b;
  logic       m_de, m_hs, m_vs;
  int         hs_low_cnt = 0;
  int         first_fall = -1;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic modelReset();
    e         = 0;
    pix_count = 0;
    m_pat     = 0;
    inc_edge  = -1;
    high_left = 0;
    low_left  = 0;
    load_edge = 0;
    loaded    = 1'b0;
    for (int i = 0; i < 3; i++) m_disp[i] = 0;
    for (int i = 0; i < 4; i++) m_word[i] = 10'd0;
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
    m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1;
  endtask

  function automatic logic [23:0] patternColour(input int h, input int v, input int pat);
    case (pat)
      0:       return bars[h / 80];
      1:       return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2:       return {8'((h / 4) % 256), 8'((v / 2) % 256), 8'h00};
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic encodeLane(input int lane, input logic [7:0] d, input logic de,
                            input logic [1:0] c, output logic [9:0] w);
    int         n1, ones, zeros;
    bit         use_xnor;
    logic [8:0] qm;
    if (!de) begin
      case (c)
        2'b00:   w = 10'b1101010100;
        2'b01:   w = 10'b0010101011;
        2'b10:   w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
      m_disp[lane] = 0;
    end else begin
      n1       = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm       = 9'd0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if (m_disp[lane] == 0 || ones == zeros) begin
        w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_disp[lane] += qm[8] ? (ones - zeros) : (zeros - ones);
      end else if ((m_disp[lane] > 0 && ones > zeros) || (m_disp[lane] < 0 && zeros > ones)) begin
        w = {1'b1, qm[8], ~qm[7:0]};
        m_disp[lane] += 2 * int'(qm[8]) + zeros - ones;
      end else begin
        w = {1'b0, qm[8], qm[7:0]};
        m_disp[lane] += -2 * int'(!qm[8]) + ones - zeros;
      end
    end
  endtask

  // Advances the model across rising edge e. Every tenth edge the previous
  // pixel's words are loaded and the next raster pixel is captured.
  task automatic modelEdge();
    int          h, v;
    logic [23:0] col;
    if (e % 10 == 0) begin
      encodeLane(0, m_b, m_de, {m_vs, m_hs}, m_word[0]);
      encodeLane(1, m_g, m_de, 2'b00, m_word[1]);
      encodeLane(2, m_r, m_de, 2'b00, m_word[2]);
      m_word[3] = 10'b1111100000;
      load_edge = e;
      loaded    = 1'b1;
      h = pix_count % 800;
      v = (pix_count / 800) % 525;
      pix_count++;
      m_de = (h < 640) && (v < 480);
      col  = m_de ? patternColour(h, v, m_pat) : 24'h000000;
      {m_r, m_g, m_b} = col;
      m_hs = !(h >= 656 && h <= 751);
      m_vs = !(v == 490 || v == 491);
    end
    if (e == inc_edge) begin
      m_pat    = (m_pat + 1) % 4;
      inc_edge = -1;
    end
  endtask

  // Drives btnd for the coming edge. Each event is a random glitch (shorter
  // than DB) or hold (at least DB), followed by a long low gap. A hold whose
  // first high is seen at edge s is accepted two sync stages plus DB clocks
  // later, at edge s+DB+1.
  task automatic applyStimulus();
    int len;
    if (high_left == 0 && low_left == 0) begin
      len       = ($urandom_range(1) == 1) ? int'($urandom_range(DB - 1, 1))
                                            : int'($urandom_range(3 * DB, DB));
      high_left = len;
      low_left  = int'($urandom_range(DB + 1500, DB + 4));
      if (len >= DB) inc_edge = (e + 1) + DB + 1;
    end
    if (high_left > 0) begin
      btnd = 1'b1;
      high_left--;
    end else begin
      btnd = 1'b0;
      low_left--;
    end
  endtask

  task automatic checkModel();
    logic [3:0] exp_p;
    for (int i = 0; i < 4; i++) exp_p[i] = loaded ? m_word[i][e - load_edge] : 1'b0;
    checkOutput("tmds", 32'({TX0_TMDS_N, TX0_TMDS_P}), 32'({~exp_p, exp_p}));
    checkOutput("vga", 32'({Hsync, Vsync, vgaRed, vgaGreen, vgaBlue}),
                32'({m_hs, m_vs, m_r[7:5], m_g[7:5], m_b[7:6]}));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tmds"}, 32'({TX0_TMDS_N, TX0_TMDS_P}), 32'h000000F0);
    checkOutput({tag, "_vga"}, 32'({Hsync, Vsync, vgaRed, vgaGreen, vgaBlue}), 32'h00000300);
  endtask

  // Checks the current state, then steps stimulus and model across one edge.
  task automatic runCycles(input int n, input bit measure);
    logic prev_hs;
    prev_hs = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkModel();
      if (measure && e >= 1 && e <= 8000) begin
        if (!Hsync) hs_low_cnt++;
        if (!Hsync && prev_hs && first_fall < 0) first_fall = e;
      end
      prev_hs = Hsync;
      applyStimulus();
      e++;
      modelEdge();
      @(negedge CLK100);
    end
  endtask

  initial begin
    btns = 1'b0;
    btnd = 1'b0;
    modelReset();
    #20 btns = 1'b1;
    #5;
    checkResetState("reset_pulse");
    repeat (8) @(negedge CLK100);
    btns = 1'b0;
    runCycles(20000, 1'b1);
    checkOutput("hsync_low_cycles", 32'(hs_low_cnt), 32'd960);
    checkOutput("hsync_first_fall", 32'(first_fall), 32'd6570);

    // Reset dropped in between clock edges, mid-line and mid-word.
    #2;
    btns = 1'b1;
    btnd = 1'b0;
    #1;
    checkResetState("async_reset");
    @(negedge CLK100);
    @(negedge CLK100);
    checkResetState("reset_hold");
    btns = 1'b0;
    modelReset();
    runCycles(40000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
